// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and status-bit indices shared by the UART bus blocks
package uart_pkg;
    typedef enum logic [3:0] {
        STATE_IDLE, STATE_START,
        STATE_BIT_0, STATE_BIT_1, STATE_BIT_2, STATE_BIT_3,
        STATE_BIT_4, STATE_BIT_5, STATE_BIT_6, STATE_BIT_7,
        STATE_STOP
    } state_t;
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_FULL = 1;
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO; full/empty from extra-MSB pointer compare, dout valid while !empty
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wp, rp;
    logic [WIDTH-1:0] mem [DEPTH];
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/wbs_uart_tx.sv
// wbs_uart_tx: Wishbone pipelined-slave UART transmitter, 8N1, static baud, FIFO-buffered
module wbs_uart_tx
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BAUD = 0,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic       wb_stall_o,
    output logic       irq_uart_tx,
    output logic       uart_tx
);
    localparam int CW = TICKS_PER_BAUD > 1 ? $clog2(TICKS_PER_BAUD) : 1;
    generate
        if (TICKS_PER_BAUD < 2) begin : g_bad_baud
            $error("wbs_uart_tx: TICKS_PER_BAUD must be >= 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("wbs_uart_tx: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate
    state_t state, state_n;
    logic [CW-1:0] baud_cnt;
    logic [7:0] shift_reg, shift_n, fifo_dout, status;
    logic accept, push, pop, tick_end, stop_end, fifo_full, fifo_empty, busy, line_n;
    assign wb_stall_o = fifo_full;
    assign accept = wb_stb_i & ~wb_stall_o;
    assign push = accept & wb_we_i;
    assign tick_end = state != STATE_IDLE && baud_cnt == CW'(TICKS_PER_BAUD - 1);
    assign stop_end = state == STATE_STOP && tick_end;
    assign pop = ~fifo_empty & (state == STATE_IDLE | stop_end);
    assign busy = state != STATE_IDLE | ~fifo_empty;
    fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(push), .pop(pop), .din(wb_dat_i),
        .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
    );
    // Line level is derived from the next state so uart_tx stays a plain flop
    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        if (pop) begin
            state_n = STATE_START;
            shift_n = fifo_dout;
        end else if (tick_end) begin
            state_n = state == STATE_STOP ? STATE_IDLE : state_t'(state + 4'd1);
        end
        line_n = state_n == STATE_START ? 1'b0 :
                 (state_n == STATE_IDLE || state_n == STATE_STOP) ? 1'b1 :
                 shift_n[3'(state_n - STATE_BIT_0)];
        status = '0;
        status[STATUS_BUSY] = busy;
        status[STATUS_FULL] = fifo_full;
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= STATE_IDLE;
            baud_cnt    <= '0;
            shift_reg   <= '0;
            uart_tx     <= 1'b1;
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            irq_uart_tx <= 1'b0;
        end else begin
            state       <= state_n;
            shift_reg   <= shift_n;
            uart_tx     <= line_n;
            baud_cnt    <= (state == STATE_IDLE || tick_end) ? '0 : baud_cnt + 1'b1;
            wb_ack_o    <= accept;
            if (accept && !wb_we_i) wb_dat_o <= status;
            irq_uart_tx <= ~accept & (irq_uart_tx | (stop_end & fifo_empty));
        end
    end
endmodule

// File: tb/tb_wbs_uart_tx.sv
// tb_wbs_uart_tx: directed bench for wbs_uart_tx at 4 ticks/baud, 4-deep FIFO
module tb_wbs_uart_tx;
    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       wb_stb_i = 1'b0;
    logic       wb_we_i  = 1'b0;
    logic [7:0] wb_dat_i = 8'h00;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o, wb_stall_o, irq_uart_tx, uart_tx;
    int checks = 0;
    int errors = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wbs_uart_tx #(.TICKS_PER_BAUD(4), .FIFO_DEPTH(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
        .irq_uart_tx(irq_uart_tx), .uart_tx(uart_tx)
    );

    // Called on a falling edge; returns on the next falling edge with the ack visible.
    task automatic bus(input bit we, input logic [7:0] d);
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_dat_i = d;
        @(negedge wb_clk_i);
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    // Checks 40 samples of one frame; without seek the start bit must be on the line now.
    task automatic check_frame(input logic [7:0] b, input bit seek, input string name);
        logic exp_bit;
        bit found;
        found = 1'b1;
        if (seek) begin
            found = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (uart_tx === 1'b0) begin
                    found = 1'b1;
                    break;
                end
                @(negedge wb_clk_i);
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL %s start: got no start bit, required one within 200 cycles", name);
            end
        end
        if (found) begin
            for (int i = 0; i < 40; i++) begin
                exp_bit = i < 4 ? 1'b0 : i >= 36 ? 1'b1 : b[i/4-1];
                checks++;
                if (uart_tx !== exp_bit) begin
                    errors++;
                    $display("FAIL %s sample %0d: got uart_tx=%b required %b", name, i, uart_tx, exp_bit);
                end
                @(negedge wb_clk_i);
            end
        end
    endtask

    task automatic test_reset;
        wb_rst_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge wb_clk_i);
            checks++;
            if (uart_tx !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle line cycle %0d: got %b required 1", i, uart_tx);
            end
            checks++;
            if ({wb_ack_o, wb_stall_o, irq_uart_tx} !== 3'b000 || wb_dat_o !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle outputs cycle %0d: got ack/stall/irq=%b dat=%h required 000/00",
                         i, {wb_ack_o, wb_stall_o, irq_uart_tx}, wb_dat_o);
            end
        end
    endtask

    task automatic test_single_byte;
        bus(1'b1, 8'hA5);
        checks++;
        if (wb_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL single ack: got %b required 1", wb_ack_o);
        end
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL single early_line: got %b required 1", uart_tx);
        end
        @(negedge wb_clk_i);
        check_frame(8'hA5, 1'b0, "single");
        checks++;
        if (irq_uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL single irq: got %b required 1", irq_uart_tx);
        end
    endtask

    task automatic test_back_to_back;
        bus(1'b1, 8'h00);
        checks++;
        if (wb_ack_o !== 1'b1 || irq_uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL b2b first_write: got ack=%b irq=%b required ack=1 irq=0", wb_ack_o, irq_uart_tx);
        end
        bus(1'b1, 8'hFF);
        checks++;
        if (wb_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b second_ack: got %b required 1", wb_ack_o);
        end
        check_frame(8'h00, 1'b1, "b2b_first");
        checks++;
        if (irq_uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL b2b mid_irq: got %b required 0", irq_uart_tx);
        end
        check_frame(8'hFF, 1'b0, "b2b_second");
        checks++;
        if (irq_uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL b2b end_irq: got %b required 1", irq_uart_tx);
        end
    endtask

    task automatic test_full_stall;
        int acks;
        bit stall_seen;
        acks = 0;
        stall_seen = 1'b0;
        fork
            begin
                wb_stb_i = 1'b1;
                wb_we_i  = 1'b1;
                wb_dat_i = 8'h01;
                for (int c = 0; c < 300 && acks < 6; c++) begin
                    @(negedge wb_clk_i);
                    if (wb_stall_o) stall_seen = 1'b1;
                    if (wb_ack_o) begin
                        acks++;
                        wb_dat_i = 8'(acks + 1);
                    end
                end
                wb_stb_i = 1'b0;
                wb_we_i  = 1'b0;
            end
            begin
                check_frame(8'h01, 1'b1, "full_1");
                for (int k = 2; k <= 6; k++) check_frame(8'(k), 1'b0, "full_n");
            end
        join
        checks++;
        if (acks !== 6) begin
            errors++;
            $display("FAIL full acks: got %0d required 6", acks);
        end
        checks++;
        if (stall_seen !== 1'b1) begin
            errors++;
            $display("FAIL full stall_seen: got %b required 1", stall_seen);
        end
        checks++;
        if (wb_stall_o !== 1'b0 || irq_uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL full end_state: got stall=%b irq=%b required stall=0 irq=1", wb_stall_o, irq_uart_tx);
        end
    endtask

    task automatic test_irq_race;
        bus(1'b1, 8'h5A);
        checks++;
        if (wb_ack_o !== 1'b1 || irq_uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL race write: got ack=%b irq=%b required ack=1 irq=0", wb_ack_o, irq_uart_tx);
        end
        @(negedge wb_clk_i);
        checks++;
        if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL race start_latency: got %b required 0", uart_tx);
        end
        repeat (39) @(negedge wb_clk_i);
        bus(1'b0, 8'h00);
        checks++;
        if (wb_ack_o !== 1'b1 || irq_uart_tx !== 1'b0 || wb_dat_o !== 8'h01) begin
            errors++;
            $display("FAIL race stop_read: got ack=%b irq=%b dat=%h required ack=1 irq=0 dat=01",
                     wb_ack_o, irq_uart_tx, wb_dat_o);
        end
        bus(1'b0, 8'h00);
        checks++;
        if (wb_dat_o !== 8'h00 || irq_uart_tx !== 1'b0 || uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL race next_read: got dat=%h irq=%b line=%b required dat=00 irq=0 line=1",
                     wb_dat_o, irq_uart_tx, uart_tx);
        end
    endtask

    task automatic test_reset_midframe;
        bus(1'b1, 8'h3C);
        bus(1'b1, 8'h11);
        bus(1'b1, 8'h22);
        repeat (8) @(negedge wb_clk_i);
        checks++;
        if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL midrst bit1: got %b required 0", uart_tx);
        end
        repeat (8) @(negedge wb_clk_i);
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL midrst bit3: got %b required 1", uart_tx);
        end
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        checks++;
        if (uart_tx !== 1'b1 || {wb_ack_o, wb_stall_o, irq_uart_tx} !== 3'b000 || wb_dat_o !== 8'h00) begin
            errors++;
            $display("FAIL midrst after_reset: got line=%b ack/stall/irq=%b dat=%h required 1/000/00",
                     uart_tx, {wb_ack_o, wb_stall_o, irq_uart_tx}, wb_dat_o);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge wb_clk_i);
            checks++;
            if (uart_tx !== 1'b1) begin
                errors++;
                $display("FAIL midrst quiet cycle %0d: got %b required 1", i, uart_tx);
            end
        end
        bus(1'b0, 8'h00);
        checks++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== 8'h00) begin
            errors++;
            $display("FAIL midrst status: got ack=%b dat=%h required ack=1 dat=00", wb_ack_o, wb_dat_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full_stall();
        test_irq_race();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
